pe_rs: RTL and testbench
========================

PE_RS -- requirements
Module: pe_rs

Interface
REQ-001 Parameter BITWIDTH, default 16, signed width of ifmap, filter, input_psum and output_psum.
REQ-002 Parameter FILTER_DEPTH, default 8, filter scratchpad entries and maximum filter row length.
REQ-003 Parameter WIN_W, default 8, width of the window-count configuration.
REQ-004 Parameter SATURATE, default 1: 1 = saturate output to BITWIDTH, 0 = truncate to low BITWIDTH bits.
REQ-005 Derived constants: LEN_W = clog2(FILTER_DEPTH)+1; ACC_W = 2*BITWIDTH+LEN_W+1.
REQ-006 Ports (name  direction  width  meaning):
 clk  in  1  sole clock, rising edge.
 rstb  in  1  reset, synchronous, active-low.
 start  in  1  one-cycle pulse; latches cfg_len, cfg_windows and cfg_acc_psum.
 cfg_len  in  LEN_W  filter row length, legal range 1..FILTER_DEPTH.
 cfg_windows  in  WIN_W  number of output psums to produce, legal range >=1.
 cfg_acc_psum  in  1  1 = add input_psum from the lower PE before output.
 busy  out  1  high in every state except IDLE.
 done  out  1  one-cycle pulse after the last window's output handshake.
 cfg_err  out  1  one-cycle pulse when start carries illegal configuration.
 filter_valid / filter_ready / filter  in / out / BITWIDTH  filter load stream.
 ifmap_valid / ifmap_ready / ifmap  in / out / BITWIDTH  activation stream.
 psum_in_valid / psum_in_ready / input_psum  in / out / BITWIDTH  psum from the lower PE.
 psum_out_valid / psum_out_ready / output_psum  out / in / BITWIDTH  psum to the upper PE.

Function
REQ-007 A transfer occurs on any stream only in a cycle where valid and ready are both high at the rising edge of clk.
REQ-008 FSM states are IDLE, LOAD, MAC, PSUM and OUT.
REQ-009 IDLE: on start with legal cfg, latch cfg and go to LOAD; on start with illegal cfg (cfg_len=0, cfg_len>FILTER_DEPTH or cfg_windows=0), pulse cfg_err, stay in IDLE and latch nothing.
REQ-010 start SHALL be ignored while busy=1, and no cfg_err SHALL be raised.
REQ-011 LOAD: filter_ready=1; transfer k writes filter[k] to scratchpad entry k; after cfg_len transfers go to MAC.
REQ-012 MAC: ifmap_ready=1; transfer j (0-based) computes acc = (j==0 ? 0 : acc) + sext(ifmap*filter[j]), using the full 2*BITWIDTH signed product sign-extended to ACC_W.
REQ-013 MAC throughput is one ifmap per cycle with no bubbles; after cfg_len transfers go to PSUM if cfg_acc_psum=1, else to OUT.
REQ-014 PSUM: psum_in_ready=1; on transfer, acc += sext(input_psum), then go to OUT.
REQ-015 OUT: psum_out_valid=1 and output_psum=f(acc), where f saturates to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1] when SATURATE=1 and takes acc[BITWIDTH-1:0] otherwise.
REQ-016 output_psum and psum_out_valid SHALL stay stable while psum_out_valid=1 and psum_out_ready=0.
REQ-017 On an OUT transfer, increment the window counter; if the count equals cfg_windows, pulse done and go to IDLE, else go to MAC and reuse the filter scratchpad (filter stationary, no reload).
REQ-018 Every ready output and psum_out_valid SHALL be 0 outside its own state.
REQ-019 The latency from the last ifmap transfer to psum_out_valid=1 is 1 cycle without the psum step, and 1 cycle after the psum_in transfer with it.
REQ-020 Filter scratchpad contents SHALL persist across windows and across return to IDLE; entries at or beyond cfg_len are unused.
REQ-021 Valid inputs in non-accepting states SHALL be ignored and cause no state change.

Reset
REQ-022 While rstb=0 at a rising clk edge: go to IDLE; clear acc, the window counter and the latched cfg; drive busy, done, cfg_err, all ready outputs and psum_out_valid to 0; drive output_psum to 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse; filter scratchpad contents after reset are don't-care.

Verification
REQ-024 cfg_len=3, windows=1, acc_psum=0, filter {2,-3,4}, ifmap {5,6,7} -> output_psum=20 one cycle after the 3rd ifmap, done pulses after the handshake.
REQ-025 BITWIDTH=16, SATURATE=1, cfg_len=2, filter {32767,32767}, ifmap {32767,32767} -> output_psum=32767; with SATURATE=0 -> low 16 bits of 2*32767^2.
REQ-026 cfg_acc_psum=1, MAC result -10, input_psum=4 -> output_psum=-6; psum_in_ready high only in PSUM.
REQ-027 windows=3 with psum_out_ready held low 5 cycles per window -> output_psum stable throughout each stall, exactly 3 outputs, no filter_ready after LOAD, a single done.
REQ-028 start with cfg_len=0 -> cfg_err pulse and busy stays 0; start while busy -> ignored; rstb=0 during MAC -> IDLE next cycle, no done, all valid/ready outputs low.

Source files
------------

// File: rtl/pe_rs.sv
// Row-stationary processing element: loads a filter row once, then produces
// cfg_windows partial sums of ifmap*filter dot products, optionally adding the lower PE's psum.
module pe_rs #(
  parameter int BITWIDTH     = 16,
  parameter int FILTER_DEPTH = 8,
  parameter int WIN_W        = 8,
  parameter int SATURATE     = 1,
  parameter int LEN_W        = $clog2(FILTER_DEPTH) + 1,
  parameter int ACC_W        = 2*BITWIDTH + LEN_W + 1
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       start,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [WIN_W-1:0]           cfg_windows,
  input  logic                       cfg_acc_psum,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  input  logic                       filter_valid,
  output logic                       filter_ready,
  input  logic signed [BITWIDTH-1:0] filter,
  input  logic                       ifmap_valid,
  output logic                       ifmap_ready,
  input  logic signed [BITWIDTH-1:0] ifmap,
  input  logic                       psum_in_valid,
  output logic                       psum_in_ready,
  input  logic signed [BITWIDTH-1:0] input_psum,
  output logic                       psum_out_valid,
  input  logic                       psum_out_ready,
  output logic signed [BITWIDTH-1:0] output_psum
);

  localparam int IDX_W = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(FILTER_DEPTH);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MAC, PSUM, OUT} state_t;

  state_t                      state;
  logic [LEN_W-1:0]            len_q;
  logic [LEN_W-1:0]            idx;
  logic [WIN_W-1:0]            win_q;
  logic [WIN_W-1:0]            win_cnt;
  logic [WIN_W-1:0]            win_nxt;
  logic                        acc_psum_q;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_mac;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [2*BITWIDTH-1:0] prod;
  logic                        last_idx;
  logic                        cfg_bad;
  logic signed [BITWIDTH-1:0]  fmem [FILTER_DEPTH];

  function automatic logic signed [BITWIDTH-1:0] shape(input logic signed [ACC_W-1:0] a);
    if (SATURATE == 0) return a[BITWIDTH-1:0];
    if (a > MAXV)      return {1'b0, {(BITWIDTH-1){1'b1}}};
    if (a < MINV)      return {1'b1, {(BITWIDTH-1){1'b0}}};
    return a[BITWIDTH-1:0];
  endfunction

  always_comb begin
    prod     = ifmap * fmem[idx[IDX_W-1:0]];
    acc_mac  = ((idx == '0) ? '0 : acc) + {{(ACC_W-2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
    acc_sum  = acc + {{(ACC_W-BITWIDTH){input_psum[BITWIDTH-1]}}, input_psum};
    last_idx = (idx == len_q - LEN_W'(1));
    win_nxt  = win_cnt + WIN_W'(1);
    cfg_bad  = (cfg_len == '0) || (cfg_len > DEPTH_L) || (cfg_windows == '0);
  end

  // Scratchpad has no reset: its contents are meaningless until the next LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD && filter_valid && filter_ready)
      fmem[idx[IDX_W-1:0]] <= filter;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state          <= IDLE;
      len_q          <= '0;
      win_q          <= '0;
      acc_psum_q     <= 1'b0;
      idx            <= '0;
      win_cnt        <= '0;
      acc            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
      filter_ready   <= 1'b0;
      ifmap_ready    <= 1'b0;
      psum_in_ready  <= 1'b0;
      psum_out_valid <= 1'b0;
      output_psum    <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              len_q        <= cfg_len;
              win_q        <= cfg_windows;
              acc_psum_q   <= cfg_acc_psum;
              idx          <= '0;
              win_cnt      <= '0;
              busy         <= 1'b1;
              filter_ready <= 1'b1;
              state        <= LOAD;
            end
          end
        end
        LOAD: begin
          if (filter_valid && filter_ready) begin
            if (last_idx) begin
              idx          <= '0;
              filter_ready <= 1'b0;
              ifmap_ready  <= 1'b1;
              state        <= MAC;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        MAC: begin
          if (ifmap_valid && ifmap_ready) begin
            acc <= acc_mac;
            if (last_idx) begin
              idx         <= '0;
              ifmap_ready <= 1'b0;
              if (acc_psum_q) begin
                psum_in_ready <= 1'b1;
                state         <= PSUM;
              end else begin
                psum_out_valid <= 1'b1;
                output_psum    <= shape(acc_mac);
                state          <= OUT;
              end
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        PSUM: begin
          if (psum_in_valid && psum_in_ready) begin
            acc            <= acc_sum;
            psum_in_ready  <= 1'b0;
            psum_out_valid <= 1'b1;
            output_psum    <= shape(acc_sum);
            state          <= OUT;
          end
        end
        OUT: begin
          if (psum_out_ready) begin
            psum_out_valid <= 1'b0;
            win_cnt        <= win_nxt;
            if (win_nxt == win_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              ifmap_ready <= 1'b1;
              state       <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_rs.sv
// Scoreboard bench for pe_rs: a saturating and a truncating instance share one
// stimulus stream; expected dot products are queued and checked by a monitor.
module tb_pe_rs;
  localparam int B  = 16;
  localparam int LW = 4;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rstb, start, cfg_acc_psum;
  logic [LW-1:0] cfg_len;
  logic [WW-1:0] cfg_windows;
  logic filter_valid, ifmap_valid, psum_in_valid, psum_out_ready;
  logic signed [B-1:0] filter, ifmap, input_psum;

  logic busy, done, cfg_err, filter_ready, ifmap_ready, psum_in_ready, psum_out_valid;
  logic signed [B-1:0] output_psum;
  logic busy_t, done_t, cfg_err_t, filter_ready_t, ifmap_ready_t, psum_in_ready_t, psum_out_valid_t;
  logic signed [B-1:0] output_psum_t;

  pe_rs #(.BITWIDTH(B), .FILTER_DEPTH(8), .WIN_W(WW), .SATURATE(1)) u_dut (
    .clk(clk), .rstb(rstb), .start(start), .cfg_len(cfg_len), .cfg_windows(cfg_windows),
    .cfg_acc_psum(cfg_acc_psum), .busy(busy), .done(done), .cfg_err(cfg_err),
    .filter_valid(filter_valid), .filter_ready(filter_ready), .filter(filter),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap(ifmap),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .input_psum(input_psum),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .output_psum(output_psum));

  pe_rs #(.BITWIDTH(B), .FILTER_DEPTH(8), .WIN_W(WW), .SATURATE(0)) u_dut_t (
    .clk(clk), .rstb(rstb), .start(start), .cfg_len(cfg_len), .cfg_windows(cfg_windows),
    .cfg_acc_psum(cfg_acc_psum), .busy(busy_t), .done(done_t), .cfg_err(cfg_err_t),
    .filter_valid(filter_valid), .filter_ready(filter_ready_t), .filter(filter),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready_t), .ifmap(ifmap),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready_t), .input_psum(input_psum),
    .psum_out_valid(psum_out_valid_t), .psum_out_ready(psum_out_ready), .output_psum(output_psum_t));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  longint exp_q[$];
  int fvals[8];
  int ivals[4][8];
  int pvals[4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom());
    return int'(t);
  endfunction

  function automatic longint sat_ref(input longint a);
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  function automatic longint trunc_ref(input longint a);
    longint m;
    m = a & 64'hFFFF;
    return (m >= 32768) ? m - 65536 : m;
  endfunction

  // Monitor: pops expected sums on output handshakes and checks stall stability.
  logic prev_stall = 1'b0;
  logic signed [B-1:0] prev_out, prev_out_t;
  always @(negedge clk) begin
    if (!rstb) begin
      prev_stall = 1'b0;
    end else begin
      chk("twin_ctrl", {busy_t, done_t, cfg_err_t, filter_ready_t, ifmap_ready_t, psum_in_ready_t, psum_out_valid_t},
                       {busy, done, cfg_err, filter_ready, ifmap_ready, psum_in_ready, psum_out_valid});
      if (prev_stall) begin
        chk("stall_valid", psum_out_valid, 1);
        chk("stall_out", output_psum, prev_out);
        chk("stall_out_t", output_psum_t, prev_out_t);
      end
      if (psum_out_valid && psum_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          longint e;
          e = exp_q.pop_front();
          chk("out_sat", output_psum, sat_ref(e));
          chk("out_trunc", output_psum_t, trunc_ref(e));
        end
      end
      prev_stall = psum_out_valid && !psum_out_ready;
      prev_out   = output_psum;
      prev_out_t = output_psum_t;
    end
  end

  task automatic start_op(input int len, input int nwin, input bit accp);
    cfg_len = LW'(len); cfg_windows = WW'(nwin); cfg_acc_psum = accp;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_filter_ready", filter_ready, 1);
    chk("start_cfg_err", cfg_err, 0);
  endtask

  task automatic load_filter(input int len, input bit gap);
    for (int k = 0; k < len; k++) begin
      int t = 0;
      bit hs;
      forever begin
        filter_valid = !gap || ($urandom_range(0, 3) != 0);
        filter = 16'(fvals[k]);
        hs = filter_valid && filter_ready;
        tick();
        if (hs) break;
        if (++t > 50) begin chk("filter_timeout", 0, 1); break; end
      end
    end
    filter_valid = 1'b0;
  endtask

  task automatic run_windows(input int len, input int nwin, input bit accp, input int stall, input bit poke);
    for (int w = 0; w < nwin; w++) begin
      longint e = 0;
      bit hs;
      int t;
      for (int j = 0; j < len; j++) e += longint'(fvals[j]) * longint'(ivals[w][j]);
      if (accp) e += longint'(pvals[w]);
      exp_q.push_back(e);
      for (int j = 0; j < len; j++) begin
        ifmap_valid = 1'b1;
        ifmap = 16'(ivals[w][j]);
        if (poke && w == 0 && j == 0) begin
          start = 1'b1; cfg_len = '0; cfg_windows = '0;
        end
        chk("ifmap_ready", ifmap_ready, 1);
        chk("filter_ready_off", filter_ready, 0);
        chk("psum_in_ready_off", psum_in_ready, 0);
        chk("out_valid_off", psum_out_valid, 0);
        tick();
        if (poke && w == 0 && j == 0) begin
          start = 1'b0;
          chk("cfg_err_busy", cfg_err, 0);
          chk("busy_after_poke", busy, 1);
        end
      end
      ifmap_valid = 1'b0;
      if (accp) begin
        chk("psum_in_ready_on", psum_in_ready, 1);
        chk("out_valid_early", psum_out_valid, 0);
        repeat ($urandom_range(0, 2)) tick();
        t = 0;
        forever begin
          psum_in_valid = 1'b1;
          input_psum = 16'(pvals[w]);
          hs = psum_in_ready;
          tick();
          if (hs) break;
          if (++t > 20) begin chk("psum_timeout", 0, 1); break; end
        end
        psum_in_valid = 1'b0;
      end
      chk("latency", psum_out_valid, 1);
      chk("ifmap_ready_out", ifmap_ready, 0);
      chk("psum_in_ready_out", psum_in_ready, 0);
      repeat (stall) tick();
      t = 0;
      forever begin
        psum_out_ready = 1'b1;
        hs = psum_out_valid;
        tick();
        if (hs) break;
        if (++t > 20) begin chk("out_timeout", 0, 1); break; end
      end
      psum_out_ready = 1'b0;
      chk("done", done, (w == nwin-1) ? 1 : 0);
      chk("busy", busy, (w == nwin-1) ? 0 : 1);
    end
    tick();
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_op(input int len, input int nwin, input bit accp, input int stall, input bit gap, input bit poke);
    start_op(len, nwin, accp);
    load_filter(len, gap);
    run_windows(len, nwin, accp, stall, poke);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_cfg_err"}, cfg_err, 0);
    chk({name, "_readies"}, {filter_ready, ifmap_ready, psum_in_ready}, 0);
    chk({name, "_valid"}, psum_out_valid, 0);
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; cfg_len = '0; cfg_windows = '0; cfg_acc_psum = 1'b0;
    filter_valid = 1'b0; ifmap_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    filter = '0; ifmap = '0; input_psum = '0;
    tick(); tick();
    check_quiet("reset");
    chk("reset_out", output_psum, 0);
    rstb = 1'b1;
    tick();

    // Short dot product {2,-3,4}.{5,6,7} = 20
    fvals[0:2] = '{2, -3, 4};
    ivals[0][0:2] = '{5, 6, 7};
    do_op(3, 1, 0, 0, 0, 0);

    // Saturation vs truncation of 2*32767^2
    fvals[0:1] = '{32767, 32767};
    ivals[0][0:1] = '{32767, 32767};
    do_op(2, 1, 0, 1, 0, 0);

    // MAC result -10 plus input psum 4
    fvals[0:1] = '{2, 0};
    ivals[0][0:1] = '{-5, 3};
    pvals[0] = 4;
    do_op(2, 1, 1, 0, 0, 0);

    // Three windows, five stall cycles each, with an ignored start during MAC
    for (int k = 0; k < 8; k++) fvals[k] = rnd16();
    for (int w = 0; w < 4; w++) for (int j = 0; j < 8; j++) ivals[w][j] = rnd16();
    do_op(4, 3, 0, 5, 1, 1);

    // Illegal configurations
    for (int c = 0; c < 3; c++) begin
      cfg_len = (c == 1) ? LW'(9) : ((c == 0) ? LW'(0) : LW'(3));
      cfg_windows = (c == 2) ? WW'(0) : WW'(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      chk("cfg_err_frdy", filter_ready, 0);
      tick();
      chk("cfg_err_single", cfg_err, 0);
    end

    // Reset during MAC aborts without done
    for (int k = 0; k < 8; k++) fvals[k] = rnd16();
    start_op(4, 2, 0);
    load_filter(4, 0);
    ifmap_valid = 1'b1; ifmap = 16'(rnd16());
    tick(); tick();
    ifmap_valid = 1'b0;
    rstb = 1'b0;
    tick();
    check_quiet("abort");
    rstb = 1'b1;
    tick();
    check_quiet("post_abort");

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      int len, nwin, stall;
      bit accp;
      len = $urandom_range(1, 8);
      nwin = $urandom_range(1, 4);
      accp = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      for (int k = 0; k < 8; k++) fvals[k] = rnd16();
      for (int w = 0; w < 4; w++) begin
        for (int j = 0; j < 8; j++) ivals[w][j] = rnd16();
        pvals[w] = rnd16();
      end
      do_op(len, nwin, accp, stall, 1, 1'(n % 3 == 0));
    end

    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
